// File: rtl/aes_pkg.sv
// Shared AES types, forward/inverse S-box tables and the SubBytes engine FSM encoding.
// The inverse table is only referenced by sbox_inv(), used when SUB_BYTES_INV_SBOX_EN is defined.
package aes_pkg;

  typedef logic [7:0]       byte_t;
  typedef logic [3:0][7:0]  word_t;
  typedef logic [15:0][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic byte_t sbox_fwd(input byte_t b);
    return SBOX[b];
  endfunction

  function automatic byte_t sbox_inv(input byte_t b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane: a single byte substituted per cycle, no internal state.
// With SUB_BYTES_INV_SBOX_EN defined, an inv select chooses the inverse table.
module sbox_lane
  import aes_pkg::*;
(
`ifdef SUB_BYTES_INV_SBOX_EN
  input  logic  inv,
`endif
  input  byte_t plain,
  output byte_t subst
);

`ifdef SUB_BYTES_INV_SBOX_EN
  // forward or inverse lookup selected per operation
  always_comb begin
    subst = inv ? sbox_inv(plain) : sbox_fwd(plain);
  end
`else
  // forward lookup only
  always_comb begin
    subst = sbox_fwd(plain);
  end
`endif

endmodule

// File: rtl/sub_bytes_seq.sv
// Time-multiplexed SubBytes engine: LANES S-boxes sweep the state MSB-first, in place.
// Optional SUB_BYTES_INV_SBOX_EN adds the inv port for InvSubBytes.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  logic   word_mode,
`ifdef SUB_BYTES_INV_SBOX_EN
  input  logic   inv,
`endif
  input  state_t state_in,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t state_out,
  output logic   busy
);

  localparam int N_FULL = 16 / LANES;
  localparam int N_WORD = (LANES >= 4) ? 1 : (4 / LANES);
  localparam int CNT_W  = (N_FULL > 1) ? $clog2(N_FULL) : 1;
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(N_FULL - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORD - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  fsm_t             state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  state_t           work_r, work_nxt_s;
  logic             word_r, word_nxt_s;
  logic             accept_s;
  logic             last_s;
  logic [3:0]       lane_pos_s [LANES];
  logic [3:0]       lane_idx_s [LANES];
  logic             lane_act_s [LANES];
  byte_t            lane_in_s  [LANES];
  byte_t            lane_out_s [LANES];
`ifdef SUB_BYTES_INV_SBOX_EN
  logic             inv_r, inv_nxt_s;
`endif

  assign accept_s = in_valid && in_ready;
  assign last_s   = (cnt_r == (word_r ? LAST_WORD : LAST_FULL));

  // lane j of group k works on byte 15-(k*LANES+j), or 3-(k*LANES+j) in word mode
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_pos_s[j] = 4'(int'(cnt_r) * LANES + j);
      if (word_r) begin
        lane_act_s[j] = (lane_pos_s[j] < 4'd4);
        lane_idx_s[j] = lane_act_s[j] ? (4'd3 - lane_pos_s[j]) : 4'd0;
      end else begin
        lane_act_s[j] = 1'b1;
        lane_idx_s[j] = 4'd15 - lane_pos_s[j];
      end
      lane_in_s[j] = work_r[lane_idx_s[j]];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox_lane u_lane (
`ifdef SUB_BYTES_INV_SBOX_EN
      .inv   (inv_r),
`endif
      .plain (lane_in_s[g]),
      .subst (lane_out_s[g])
    );
  end

  // next-state, counter and in-place write-back of the working state
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    work_nxt_s  = work_r;
    word_nxt_s  = word_r;
`ifdef SUB_BYTES_INV_SBOX_EN
    inv_nxt_s   = inv_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = {CNT_W{1'b0}};
          work_nxt_s  = state_in;
          word_nxt_s  = word_mode;
`ifdef SUB_BYTES_INV_SBOX_EN
          inv_nxt_s   = inv;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        // idle lanes (word mode, LANES > 4) rewrite byte 0 with its current value
        for (int j = 0; j < LANES; j++) begin
          work_nxt_s[lane_idx_s[j]] = lane_act_s[j] ? lane_out_s[j] : work_nxt_s[lane_idx_s[j]];
        end
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // state, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      work_r    <= 128'h0;
      word_r    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      state_out <= 128'h0;
`ifdef SUB_BYTES_INV_SBOX_EN
      inv_r     <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      work_r    <= work_nxt_s;
      word_r    <= word_nxt_s;
      in_ready  <= (state_nxt_s == IDLE);
      out_valid <= (state_nxt_s == DONE);
      busy      <= (state_nxt_s != IDLE);
`ifdef SUB_BYTES_INV_SBOX_EN
      inv_r     <= inv_nxt_s;
`endif
      if ((state_r == RUN) && (state_nxt_s == DONE)) begin
        state_out <= work_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq: one instance per legal LANES value, table-driven vectors
// plus backpressure and reset-abort sequences.
module tb_sub_bytes_seq;

  localparam int NDUT = 5;  // instance g has LANES = 1 << g

  localparam logic [127:0] R1_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R1_OUT  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] W_IN    = 128'haaaaaaaaaaaaaaaaaaaaaaaacf4f3c09;
  localparam logic [127:0] W_OUT   = 128'haaaaaaaaaaaaaaaaaaaaaaaa8a84eb01;
  localparam logic [127:0] Z_OUT   = 128'h63636363636363636363636363636363;
  localparam logic [127:0] SQ_IN   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SQ_OUT  = 128'h638293c31bfc33f5c4eeacea4bc12816;
`ifdef SUB_BYTES_INV_SBOX_EN
  localparam logic [127:0] IW_IN   = 128'haaaaaaaaaaaaaaaaaaaaaaaa63ed6363;
  localparam logic [127:0] IW_OUT  = 128'haaaaaaaaaaaaaaaaaaaaaaaa00530000;
`endif

  typedef struct {
    int           dut;
    logic         word;
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic [NDUT-1:0]   in_valid;
  logic [NDUT-1:0]   in_ready;
  logic [NDUT-1:0]   out_valid;
  logic [NDUT-1:0]   out_ready;
  logic [NDUT-1:0]   busy;
  logic              word_mode;
  logic [127:0]      state_in;
  logic [127:0]      state_out [NDUT];
`ifdef SUB_BYTES_INV_SBOX_EN
  logic              inv;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sub_bytes_seq #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .word_mode (word_mode),
`ifdef SUB_BYTES_INV_SBOX_EN
      .inv       (inv),
`endif
      .state_in  (state_in),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .state_out (state_out[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int d, input logic w, input logic i,
                              input logic [127:0] din, input logic [127:0] exp, input int lat);
    vec_t v;
    v.dut = d; v.word = w; v.inv = i; v.din = din; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // offer one block, measure latency from the accepting edge, check result and return to idle
  task automatic run_vec(input string tag, input vec_t v);
    int d;
    int lat;
    d = v.dut;
    check({tag, "_ready_before"}, 128'(in_ready[d]), 128'd1);
    @(negedge clk);
    state_in    = v.din;
    word_mode   = v.word;
`ifdef SUB_BYTES_INV_SBOX_EN
    inv         = v.inv;
`endif
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    check({tag, "_busy_after_accept"}, 128'(busy[d]), 128'd1);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid[d]) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, 128'(lat), 128'(v.lat));
    check({tag, "_data"}, state_out[d], v.exp);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 128'(out_valid[d]), 128'd0);
    check({tag, "_ready_after"}, 128'(in_ready[d]), 128'd1);
  endtask

  initial begin
    int seen;

    vecs.push_back(mk(2, 1'b0, 1'b0, R1_IN, R1_OUT, 4));
    vecs.push_back(mk(0, 1'b0, 1'b0, R1_IN, R1_OUT, 16));
    vecs.push_back(mk(1, 1'b0, 1'b0, R1_IN, R1_OUT, 8));
    vecs.push_back(mk(3, 1'b0, 1'b0, R1_IN, R1_OUT, 2));
    vecs.push_back(mk(4, 1'b0, 1'b0, R1_IN, R1_OUT, 1));
    vecs.push_back(mk(3, 1'b1, 1'b0, W_IN, W_OUT, 1));
    vecs.push_back(mk(0, 1'b1, 1'b0, W_IN, W_OUT, 4));
    vecs.push_back(mk(1, 1'b1, 1'b0, W_IN, W_OUT, 2));
    vecs.push_back(mk(2, 1'b1, 1'b0, W_IN, W_OUT, 1));
    vecs.push_back(mk(4, 1'b1, 1'b0, W_IN, W_OUT, 1));
    vecs.push_back(mk(2, 1'b0, 1'b0, 128'h0, Z_OUT, 4));
    vecs.push_back(mk(3, 1'b0, 1'b0, SQ_IN, SQ_OUT, 2));
    vecs.push_back(mk(0, 1'b0, 1'b0, SQ_IN, SQ_OUT, 16));
`ifdef SUB_BYTES_INV_SBOX_EN
    vecs.push_back(mk(2, 1'b0, 1'b1, R1_OUT, R1_IN, 4));
    vecs.push_back(mk(4, 1'b0, 1'b1, R1_OUT, R1_IN, 1));
    vecs.push_back(mk(2, 1'b1, 1'b1, IW_IN, IW_OUT, 1));
    vecs.push_back(mk(2, 1'b0, 1'b0, R1_IN, R1_OUT, 4));
`endif

    rst_n     = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    word_mode = 1'b0;
    state_in  = 128'h0;
`ifdef SUB_BYTES_INV_SBOX_EN
    inv       = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset_out_valid_d%0d", d), 128'(out_valid[d]), 128'd0);
      check($sformatf("reset_busy_d%0d", d), 128'(busy[d]), 128'd0);
      check($sformatf("reset_state_out_d%0d", d), state_out[d], 128'h0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("post_reset_in_ready_d%0d", d), 128'(in_ready[d]), 128'd1);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // backpressure: LANES=4 held in DONE for 10 cycles while in_valid toggles
    out_ready[2] = 1'b0;
    @(negedge clk);
    state_in = R1_IN; word_mode = 1'b0; in_valid[2] = 1'b1;
`ifdef SUB_BYTES_INV_SBOX_EN
    inv = 1'b0;
`endif
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    seen = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid[2]) begin
        seen = c;
        break;
      end
    end
    check("bp_latency", 128'(seen), 128'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      state_in    = ~R1_IN;
      in_valid[2] = k[0];
      @(posedge clk); #1;
      check($sformatf("bp_valid_c%0d", k), 128'(out_valid[2]), 128'd1);
      check($sformatf("bp_data_c%0d", k), state_out[2], R1_OUT);
      check($sformatf("bp_in_ready_c%0d", k), 128'(in_ready[2]), 128'd0);
    end
    in_valid[2] = 1'b0;
    @(negedge clk);
    out_ready[2] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 128'(out_valid[2]), 128'd0);
    check("bp_release_ready", 128'(in_ready[2]), 128'd1);
    @(posedge clk); #1;
    check("bp_no_queued_input", 128'(busy[2]), 128'd0);

    // reset abort: LANES=1, rst_n asserted during RUN cycle 2
    @(negedge clk);
    state_in = R1_IN; word_mode = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy_before", 128'(busy[0]), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 128'(out_valid[0]), 128'd0);
    check("abort_busy", 128'(busy[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready_after", 128'(in_ready[0]), 128'd1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid[0] || busy[0]) seen++;
    end
    check("abort_no_late_result", 128'(seen), 128'd0);
    run_vec("abort_recover", vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
